// File: rtl/text_msg_typewriter.sv
// Message text source for the character overlay: maps a {row, col} cell to an ASCII code,
// revealing one of four fixed messages a character at a time and optionally blinking it.
module text_msg_typewriter #(
    parameter int COL_BITS      = 4,
    parameter int ROW_BITS      = 4,
    parameter int CODE_W        = 8,
    parameter int MSG_ROW       = 0,
    parameter int REVEAL_FRAMES = 2,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [ROW_BITS+COL_BITS-1:0] i_char_yx,
    input  logic [1:0]                   i_msg_sel,
    input  logic                         i_start,
    input  logic                         i_clear,
    input  logic                         i_frame_tick,
    input  logic                         i_blink_en,
    output logic [CODE_W-1:0]            o_char_code,
    output logic                         o_done
);
    localparam int YX_W = ROW_BITS + COL_BITS;
    localparam int FMAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;

    typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_t;

    function automatic logic [3:0] msg_len(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd7;
            2'd1:    return 4'd9;
            2'd2:    return 4'd6;
            default: return 4'd11;
        endcase
    endfunction

    // Messages are left-aligned and zero-padded to 11 bytes; byte 0 is column 0.
    function automatic logic [7:0] rom_char(input logic [1:0] m, input int c);
        logic [0:10][7:0] s;
        logic [3:0]       ci;
        case (m)
            2'd0:    s = {"YOU WIN", 32'h0};
            2'd1:    s = {"GAME OVER", 16'h0};
            2'd2:    s = {"PAUSED", 40'h0};
            default: s = "PRESS START";
        endcase
        if (c < 11) begin
            ci = 4'(c);
            return s[ci];
        end
        return 8'h00;
    endfunction

    state_t          r_state, w_state_n;
    logic [1:0]      r_msg, w_msg_n;
    logic [3:0]      r_reveal_cnt, w_reveal_n;
    logic [FW-1:0]   r_frame_cnt, w_frame_n;
    logic            r_blink, w_blink_n;
    logic [CODE_W-1:0] r_char_code;
    logic            r_done;

    logic [ROW_BITS-1:0] w_row;
    logic [COL_BITS-1:0] w_col;
    logic                w_visible;

    assign w_row = i_char_yx[YX_W-1:COL_BITS];
    assign w_col = i_char_yx[COL_BITS-1:0];
    assign w_visible = (int'(w_row) == MSG_ROW) && (int'(w_col) < int'(r_reveal_cnt)) &&
                       !r_blink && (r_state != IDLE);

    always_comb begin
        w_state_n  = r_state;
        w_msg_n    = r_msg;
        w_reveal_n = r_reveal_cnt;
        w_frame_n  = r_frame_cnt;
        w_blink_n  = r_blink;
        if (i_clear) begin
            w_state_n  = IDLE;
            w_reveal_n = 4'd0;
            w_blink_n  = 1'b0;
        end else if (i_start) begin
            w_state_n  = REVEAL;
            w_msg_n    = i_msg_sel;
            w_reveal_n = 4'd0;
            w_frame_n  = '0;
            w_blink_n  = 1'b0;
        end else begin
            case (r_state)
                REVEAL: if (i_frame_tick) begin
                    if (r_frame_cnt == FW'(REVEAL_FRAMES - 1)) begin
                        w_frame_n  = '0;
                        w_reveal_n = r_reveal_cnt + 4'd1;
                        if (r_reveal_cnt + 4'd1 == msg_len(r_msg)) w_state_n = SHOW;
                    end else begin
                        w_frame_n = r_frame_cnt + FW'(1);
                    end
                end
                SHOW: if (!i_blink_en) begin
                    w_frame_n = '0;
                    w_blink_n = 1'b0;
                end else if (i_frame_tick) begin
                    if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                        w_frame_n = '0;
                        w_blink_n = !r_blink;
                    end else begin
                        w_frame_n = r_frame_cnt + FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_msg        <= 2'd0;
            r_reveal_cnt <= 4'd0;
            r_frame_cnt  <= '0;
            r_blink      <= 1'b0;
            r_char_code  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_msg        <= w_msg_n;
            r_reveal_cnt <= w_reveal_n;
            r_frame_cnt  <= w_frame_n;
            r_blink      <= w_blink_n;
            // Output uses pre-edge state/counters, so it lags the address by one clock.
            r_char_code  <= w_visible ? CODE_W'(rom_char(r_msg, int'(w_col))) : '0;
            r_done       <= (w_state_n == SHOW);
        end
    end

    assign o_char_code = r_char_code;
    assign o_done      = r_done;
endmodule
